// File: rtl/tb_lights_pkg.sv
// ---------------------------------------------------------------------------
// tb_lights_pkg
// Shared types for the taillight lamp monitor.
//   state_t      : monitor FSM states (thermometer steps per side, hazard,
//                  and RESYNC for waiting out a fault until the lamps go dark)
//   mode_t       : decoded command codes driven on the monitor's mode output
//   fault_t      : first-fault codes driven on fault_code
//   lamp_class_t : classification of one six-lamp sample
// Helpers:
//   thermo_count : lamps lit in an inner-to-outer thermometer (0 = not one)
//   lit_state    : FSM state reached when <side> shows <n> lamps
// ---------------------------------------------------------------------------
package tb_lights_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_L1     = 4'd1,
    ST_L2     = 4'd2,
    ST_L3     = 4'd3,
    ST_R1     = 4'd4,
    ST_R2     = 4'd5,
    ST_R3     = 4'd6,
    ST_HZ     = 4'd7,
    ST_RESYNC = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_HAZ   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    FLT_NONE      = 2'b00,
    FLT_BAD_PAT   = 2'b01,
    FLT_BAD_TRANS = 2'b10
  } fault_t;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  // side/lit_count are only meaningful when exactly one side is lit.
  typedef struct packed {
    logic       legal;
    logic       side;
    logic [1:0] lit_count;
    logic       all_on;
    logic       all_off;
  } lamp_class_t;

  // Bits are ordered {inner, middle, outer}.
  function automatic logic [1:0] thermo_count(input logic [2:0] lamps);
    logic [1:0] n;
    case (lamps)
      3'b100:  n = 2'd1;
      3'b110:  n = 2'd2;
      3'b111:  n = 2'd3;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic state_t lit_state(input logic side, input logic [1:0] n);
    state_t s;
    case ({side, n})
      3'b001:  s = ST_L1;
      3'b010:  s = ST_L2;
      3'b011:  s = ST_L3;
      3'b101:  s = ST_R1;
      3'b110:  s = ST_R2;
      3'b111:  s = ST_R3;
      default: s = ST_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tb_lamp_classify.sv
// ---------------------------------------------------------------------------
// tb_lamp_classify
// Purely combinational: turns one six-lamp sample into the few facts the
// monitor FSM needs, so the FSM never looks at raw lamp bits.
// Ports:
//   lamps  in  6  {LA,LB,LC,RA,RB,RC}
//   cls    out    lamp_class_t {legal, side, lit_count, all_on, all_off}
// Legal samples: all off, all on, or one side in thermometer form
// (inner, inner+middle, all three) with the other side dark.
// ---------------------------------------------------------------------------
module tb_lamp_classify
  import tb_lights_pkg::*;
(
  input  logic [5:0]  lamps,
  output lamp_class_t cls
);

  logic [2:0] left_lamps;
  logic [2:0] right_lamps;
  logic [1:0] left_n;
  logic [1:0] right_n;

  assign left_lamps  = lamps[5:3];
  assign right_lamps = lamps[2:0];
  assign left_n      = thermo_count(left_lamps);
  assign right_n     = thermo_count(right_lamps);

  always_comb begin
    cls = '0;
    if (lamps == 6'b000000) begin
      cls.legal   = 1'b1;
      cls.all_off = 1'b1;
    end else if (lamps == 6'b111111) begin
      cls.legal     = 1'b1;
      cls.all_on    = 1'b1;
      cls.lit_count = 2'd3;
    end else if (right_lamps == 3'b000 && left_n != 2'd0) begin
      cls.legal     = 1'b1;
      cls.side      = SIDE_LEFT;
      cls.lit_count = left_n;
    end else if (left_lamps == 3'b000 && right_n != 2'd0) begin
      cls.legal     = 1'b1;
      cls.side      = SIDE_RIGHT;
      cls.lit_count = right_n;
    end
  end

endmodule

// File: rtl/tb_lights_monitor.sv
// ---------------------------------------------------------------------------
// tb_lights_monitor
// Receiving-end checker for the taillight lamp interface. On every clk edge
// with tick=1 it samples the six lamps, tracks the sequencer's command and
// step, flags protocol violations and counts completed sequences.
// Ports:
//   clk         in   1      rising-edge clock
//   clear       in   1      asynchronous active-low reset
//   tick        in   1      sample strobe (one sequencer step per tick)
//   LA,LB,LC    in   1 ea   left lamps, LA innermost
//   RA,RB,RC    in   1 ea   right lamps, RA innermost
//   fault_clr   in   1      clears fault/fault_code on the next clk
//   mode        out  2      00 idle, 01 left, 10 right, 11 hazard
//   step        out  2      lamps lit per side (hazard: 1, idle/resync: 0)
//   seq_done    out  1      one-clk pulse on a legally completed sequence
//   fault       out  1      sticky protocol-violation flag
//   fault_code  out  2      first fault: 00 none, 01 bad pattern, 10 bad transition
//   seq_count   out  CNT_W  completed sequences, saturating
// Build option: define TBMON_SYNC_EN to pass the lamps and tick through a
// two-flop synchronizer (decode latency 3 clk instead of 1).
// The FSM state is the internal signal `state`; mode/step decode straight
// from it, so they are register outputs one clk after the sampling edge.
// ---------------------------------------------------------------------------
module tb_lights_monitor
  import tb_lights_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             tick,
  input  logic             LA,
  input  logic             LB,
  input  logic             LC,
  input  logic             RA,
  input  logic             RB,
  input  logic             RC,
  input  logic             fault_clr,
  output logic [1:0]       mode,
  output logic [1:0]       step,
  output logic             seq_done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] seq_count
);

  logic        s_tick;
  logic [5:0]  s_lamps;

`ifdef TBMON_SYNC_EN
  logic [6:0] sync_1;
  logic [6:0] sync_2;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {tick, LA, LB, LC, RA, RB, RC};
      sync_2 <= sync_1;
    end
  end

  assign s_tick  = sync_2[6];
  assign s_lamps = sync_2[5:0];
`else
  assign s_tick  = tick;
  assign s_lamps = {LA, LB, LC, RA, RB, RC};
`endif

  lamp_class_t cls;

  tb_lamp_classify u_classify (
    .lamps (s_lamps),
    .cls   (cls)
  );

  state_t state;
  state_t state_nx;
  logic   done_nx;
  logic   flt_nx;
  fault_t flt_code_nx;
  state_t prev_needed;

  // A lit sample of n lamps is legal only right after n-1 lamps on the same
  // side (or from IDLE for the first lamp).
  always_comb begin
    prev_needed = ST_IDLE;
    if (cls.lit_count > 2'd1) begin
      prev_needed = lit_state(cls.side, cls.lit_count - 2'd1);
    end
  end

  always_comb begin
    state_nx    = state;
    done_nx     = 1'b0;
    flt_nx      = 1'b0;
    flt_code_nx = FLT_NONE;
    if (s_tick) begin
      if (!cls.legal) begin
        // Bad patterns are flagged even while resynchronising.
        flt_nx      = 1'b1;
        flt_code_nx = FLT_BAD_PAT;
        state_nx    = ST_RESYNC;
      end else if (state == ST_RESYNC) begin
        if (cls.all_off) begin
          state_nx = ST_IDLE;
        end
      end else if (cls.all_on) begin
        // Hazard preempts any sequence; staying lit across two ticks is a
        // held pattern, not a new hazard phase.
        if (state == ST_HZ) begin
          flt_nx      = 1'b1;
          flt_code_nx = FLT_BAD_TRANS;
          state_nx    = ST_RESYNC;
        end else begin
          state_nx = ST_HZ;
        end
      end else if (cls.all_off) begin
        // Going dark from a partial step is a legal abort, not a completion.
        case (state)
          ST_L3, ST_R3, ST_HZ: done_nx = 1'b1;
          default:             done_nx = 1'b0;
        endcase
        state_nx = ST_IDLE;
      end else if (state == prev_needed) begin
        state_nx = lit_state(cls.side, cls.lit_count);
      end else begin
        flt_nx      = 1'b1;
        flt_code_nx = FLT_BAD_TRANS;
        state_nx    = ST_RESYNC;
      end
    end
  end

  always_comb begin
    mode = MODE_IDLE;
    step = 2'd0;
    case (state)
      ST_L1: begin mode = MODE_LEFT;  step = 2'd1; end
      ST_L2: begin mode = MODE_LEFT;  step = 2'd2; end
      ST_L3: begin mode = MODE_LEFT;  step = 2'd3; end
      ST_R1: begin mode = MODE_RIGHT; step = 2'd1; end
      ST_R2: begin mode = MODE_RIGHT; step = 2'd2; end
      ST_R3: begin mode = MODE_RIGHT; step = 2'd3; end
      ST_HZ: begin mode = MODE_HAZ;   step = 2'd1; end
      default: begin mode = MODE_IDLE; step = 2'd0; end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state      <= ST_IDLE;
      seq_done   <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
      seq_count  <= '0;
    end else begin
      state    <= state_nx;
      seq_done <= done_nx;
      if (done_nx && seq_count != {CNT_W{1'b1}}) begin
        seq_count <= seq_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // A fault seen in the same clk as fault_clr wins and reloads the code.
      if (flt_nx) begin
        fault <= 1'b1;
        if (fault_code == FLT_NONE || fault_clr) begin
          fault_code <= flt_code_nx;
        end
      end else if (fault_clr) begin
        fault      <= 1'b0;
        fault_code <= FLT_NONE;
      end
    end
  end

endmodule

// File: doc/tb_lights_monitor.md
Name: tb_lights_monitor

Overview:
- Receiving end of the taillight lamp interface: samples the six lamp lines (LA,LB,LC,RA,RB,RC) driven by the taillight sequencer and decodes the driver's active command (idle/left/right/hazard) and step.
- Checks every sampled pattern and transition against the lamp protocol; flags faults and counts completed sequences.
- Sits beside the sequencer in the tail-light subsystem as a self-check and status source.

Parameters:
- CNT_W, 8, width of saturating completed-sequence counter.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- tick  in  1  sample strobe; lamps sampled only on clk edges with tick=1 (one sequencer step per tick).
- LA,LB,LC  in  1 each  left lamps, LA innermost.
- RA,RB,RC  in  1 each  right lamps, RA innermost.
- fault_clr  in  1  clears fault and fault_code.
- mode  out  2  00 idle, 01 left, 10 right, 11 hazard.
- step  out  2  left/right: 1..3 lamps lit; hazard: 1 while all lamps on; idle: 0.
- seq_done  out  1  one-clk pulse on legal sequence completion.
- fault  out  1  sticky protocol-violation flag.
- fault_code  out  2  first fault: 00 none, 01 bad pattern, 10 bad transition.
- seq_count  out  CNT_W  completed sequences, saturating.

Behaviour:
- Reset (clear=0, async): all outputs 0; FSM = IDLE.
- Legal patterns per sample: all off; left thermometer LA / LA+LB / LA+LB+LC with right off; mirror for right; all six on. Anything else = bad pattern.
- FSM states: IDLE, L1, L2, L3, R1, R2, R3, HZ, RESYNC.
- IDLE: off -> IDLE; left 1-lamp -> L1; right 1-lamp -> R1; all on -> HZ; other legal pattern -> bad transition.
- Ln -> L(n+1) on next thermometer step; L3 -> IDLE on all off with seq_done=1. Same for R.
- L1/L2/R1/R2 -> IDLE on all off is a legal abort: no seq_done, no count.
- Any state except RESYNC -> HZ on all on (hazard preempts).
- HZ -> IDLE on all off with seq_done=1.
- Every other transition, including holding the same pattern across two ticks while non-idle, a skipped step, a backward step, or left<->right without idle, is a bad transition.
- On any fault: fault=1; fault_code latched only if it was 00; FSM -> RESYNC; no seq_done.
- RESYNC: stays until an all-off sample, then IDLE. mode=00, step=0 while in RESYNC.
- mode/step/seq_done are registered and valid the clk after the sampling edge: latency 1 clk.
- seq_count increments with seq_done and holds at 2^CNT_W-1.
- fault_clr=1 clears fault and fault_code next clk. If a new fault is detected in the same clk, the new fault wins: fault=1 and the new code is loaded.
- tick=0: lamps ignored, state held, seq_done=0.
- Reset mid-sequence: immediate return to IDLE; counter and fault lost.

Optional Feature:
- TBMON_SYNC_EN defined: two-flop synchronizer on all six lamp inputs and tick, each reset to 0 by clear. Decode latency becomes 3 clk.
- Undefined: inputs used directly; latency 1 clk.

Decomposition:
- Package tb_lights_pkg holds:
  - FSM state encoding.
  - mode codes IDLE/LEFT/RIGHT/HAZ.
  - fault codes NONE/BAD_PAT/BAD_TRANS.
- Sub-module tb_lamp_classify (combinational): maps the 6 lamp bits to {legal, side, lit_count, all_on, all_off}. The FSM consumes only the classified result.

Test Plan:
- Left run, tick every clk: left lamps 000,100,110,111,000 -> mode 01 with step 1,2,3, then seq_done pulse on the 000 sample, seq_count=1, fault=0.
- Hazard alternation: all on / all off ×3 -> mode 11/00 alternating, seq_count=3.
- Illegal pattern: LB only (010 left) from IDLE -> fault=1, code 01, mode 00. Holds RESYNC until all off, then a right sequence decodes normally.
- Skip and first-fault priority: L1 then 111 left -> code 10. A later bad pattern leaves code at 10. fault_clr with no new fault -> 0/00.
- Abort and preempt: L1, L2, off -> no seq_done, count unchanged. R2 then all on -> mode 11, no fault.
- Saturation and reset: CNT_W=2, 5 completed sequences -> seq_count=3. clear low mid-L2 -> all outputs 0 asynchronously.
